flash_read_arbiter: RTL and testbench

Two-port read arbiter that shares the single Avalon-MM flash read port (`flash_mem_*`) between two independent requesters. Example pairing: the hex-display reader and a sample streamer. It runs one single-word read at a time. Grants alternate round-robin when both requesters contend, and each returned word is routed back to the requester that issued the read. A watchdog recovers the port if the flash never returns data.

---
 rtl/flash_read_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_flash_read_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: shares one Avalon-MM flash read port between two
// requesters. One single-word read is in flight at a time. Contention is
// resolved round-robin, and each returned word is steered to the requester
// that issued the read. A watchdog abandons a read whose data never arrives.
module flash_read_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        req0_read,
  input  logic [22:0] req0_address,
  output logic        req0_waitrequest,
  output logic [31:0] req0_readdata,
  output logic        req0_readdatavalid,
  input  logic        req1_read,
  input  logic [22:0] req1_address,
  output logic        req1_waitrequest,
  output logic [31:0] req1_readdata,
  output logic        req1_readdatavalid,
  output logic        flash_mem_read,
  output logic [22:0] flash_mem_address,
  input  logic        flash_mem_waitrequest,
  input  logic [31:0] flash_mem_readdata,
  input  logic        flash_mem_readdatavalid,
  output logic        flash_mem_write,
  output logic [6:0]  flash_mem_burstcount,
  output logic [3:0]  flash_mem_byteenable,
  output logic [31:0] flash_mem_writedata,
  output logic        timeout_err,
  output logic        grant
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // The watchdog fires on the edge where the count would reach TIMEOUT_CYCLES.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_read_q, mem_read_d;
  logic [22:0]   mem_addr_q, mem_addr_d;
  logic          grant_q, grant_d;
  logic [1:0]    waitreq_q, waitreq_d;
  logic [1:0]    rdv_q, rdv_d;
  logic [31:0]   rdata0_q, rdata0_d;
  logic [31:0]   rdata1_q, rdata1_d;
  logic          terr_q, terr_d;
  logic          timeout_s;

  assign timeout_s = (cnt_q == TO_LAST);

  // Next-state and next-output logic for the arbitration FSM and watchdog.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_read_d   = mem_read_q;
    mem_addr_d   = mem_addr_q;
    grant_d      = grant_q;
    waitreq_d    = 2'b11;
    rdv_d        = 2'b00;
    terr_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      IDLE: begin
        if (req0_read && req1_read) begin
          // Both contend: the one not served last goes first.
          grant_d    = ~last_grant_q;
          mem_addr_d = last_grant_q ? req0_address : req1_address;
          mem_read_d = 1'b1;
          cnt_d      = '0;
          state_d    = ISSUE;
        end else if (req0_read) begin
          grant_d    = 1'b0;
          mem_addr_d = req0_address;
          mem_read_d = 1'b1;
          cnt_d      = '0;
          state_d    = ISSUE;
        end else if (req1_read) begin
          grant_d    = 1'b1;
          mem_addr_d = req1_address;
          mem_read_d = 1'b1;
          cnt_d      = '0;
          state_d    = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end

      ISSUE: begin
        cnt_d = cnt_q + CW'(1);
        if (timeout_s) begin
          // Abandon: release the requester and return a zero word.
          mem_read_d         = 1'b0;
          waitreq_d[grant_q] = 1'b0;
          rdv_d[grant_q]     = 1'b1;
          terr_d             = 1'b1;
          last_grant_d       = grant_q;
          if (grant_q) begin
            rdata1_d = 32'h0000_0000;
          end else begin
            rdata0_d = 32'h0000_0000;
          end
          state_d = IDLE;
        end else if (!flash_mem_waitrequest) begin
          mem_read_d         = 1'b0;
          waitreq_d[grant_q] = 1'b0;
          state_d            = WAIT_DATA;
        end else begin
          state_d = ISSUE;
        end
      end

      WAIT_DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (flash_mem_readdatavalid) begin
          // Data beats a simultaneous timeout.
          rdv_d[grant_q] = 1'b1;
          last_grant_d   = grant_q;
          if (grant_q) begin
            rdata1_d = flash_mem_readdata;
          end else begin
            rdata0_d = flash_mem_readdata;
          end
          state_d = IDLE;
        end else if (timeout_s) begin
          rdv_d[grant_q] = 1'b1;
          terr_d         = 1'b1;
          last_grant_d   = grant_q;
          if (grant_q) begin
            rdata1_d = 32'h0000_0000;
          end else begin
            rdata0_d = 32'h0000_0000;
          end
          state_d = IDLE;
        end else begin
          state_d = WAIT_DATA;
        end
      end

      default: begin
        mem_read_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers; reset is asynchronous and active-high.
  always_ff @(posedge clk_clk or posedge reset_reset_n) begin
    if (reset_reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      mem_read_q   <= 1'b0;
      mem_addr_q   <= 23'h000000;
      grant_q      <= 1'b0;
      waitreq_q    <= 2'b11;
      rdv_q        <= 2'b00;
      rdata0_q     <= 32'h0000_0000;
      rdata1_q     <= 32'h0000_0000;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_read_q   <= mem_read_d;
      mem_addr_q   <= mem_addr_d;
      grant_q      <= grant_d;
      waitreq_q    <= waitreq_d;
      rdv_q        <= rdv_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      terr_q       <= terr_d;
    end
  end

  assign req0_waitrequest   = waitreq_q[0];
  assign req1_waitrequest   = waitreq_q[1];
  assign req0_readdatavalid = rdv_q[0];
  assign req1_readdatavalid = rdv_q[1];
  assign req0_readdata      = rdata0_q;
  assign req1_readdata      = rdata1_q;
  assign flash_mem_read     = mem_read_q;
  assign flash_mem_address  = mem_addr_q;
  assign timeout_err        = terr_q;
  assign grant              = grant_q;

  // Read-only port: write side is tied off.
  assign flash_mem_write      = 1'b0;
  assign flash_mem_burstcount = 7'd1;
  assign flash_mem_byteenable = 4'hF;
  assign flash_mem_writedata  = 32'h0000_0000;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Testbench for flash_read_arbiter: table of transactions plus hand-written
// timeout and mid-read reset sequences, with a flash responder model and a
// scoreboard of expected returned words.
module tb_flash_read_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_read, req1_read;
  logic [22:0] req0_address, req1_address;
  logic        req0_waitrequest, req1_waitrequest;
  logic [31:0] req0_readdata, req1_readdata;
  logic        req0_readdatavalid, req1_readdatavalid;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic        mem_wait, mem_rdv;
  logic [31:0] mem_data;
  logic        flash_mem_write;
  logic [6:0]  flash_mem_burstcount;
  logic [3:0]  flash_mem_byteenable;
  logic [31:0] flash_mem_writedata;
  logic        timeout_err, grant;

  always #5 clk = ~clk;

  flash_read_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_clk                (clk),
    .reset_reset_n          (rst),
    .req0_read              (req0_read),
    .req0_address           (req0_address),
    .req0_waitrequest       (req0_waitrequest),
    .req0_readdata          (req0_readdata),
    .req0_readdatavalid     (req0_readdatavalid),
    .req1_read              (req1_read),
    .req1_address           (req1_address),
    .req1_waitrequest       (req1_waitrequest),
    .req1_readdata          (req1_readdata),
    .req1_readdatavalid     (req1_readdatavalid),
    .flash_mem_read         (flash_mem_read),
    .flash_mem_address      (flash_mem_address),
    .flash_mem_waitrequest  (mem_wait),
    .flash_mem_readdata     (mem_data),
    .flash_mem_readdatavalid(mem_rdv),
    .flash_mem_write        (flash_mem_write),
    .flash_mem_burstcount   (flash_mem_burstcount),
    .flash_mem_byteenable   (flash_mem_byteenable),
    .flash_mem_writedata    (flash_mem_writedata),
    .timeout_err            (timeout_err),
    .grant                  (grant)
  );

  typedef struct {
    logic        r0;
    logic        r1;
    logic [22:0] a0;
    logic [22:0] a1;
    int          ws;
    logic        eg;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        terr;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_fail   = 0;

  // flash responder model state
  int          ws_cfg   = 0;
  int          lat_cfg  = 2;
  bit          no_resp  = 1'b0;
  int          wcount   = 0;
  int          lat_left = 0;
  int          nacc     = 0;
  logic [22:0] p_addr   = 23'h0;
  logic        s_read   = 1'b0;
  logic        s_wait   = 1'b1;
  logic [22:0] s_addr   = 23'h0;

  function automatic logic [31:0] fdata(input logic [22:0] a);
    return {16'hCAFE, a[15:0]};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor/scoreboard checks, then the flash responder drives its inputs.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (req0_readdatavalid || req1_readdatavalid) begin
        if (req0_readdatavalid && req1_readdatavalid) begin
          chk("rdv_both", 1, 0);
        end else if (sb.size() == 0) begin
          chk("rdv_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_port_terr", int'({req1_readdatavalid, timeout_err}), int'({e.port, e.terr}));
          chk("sb_data", int'(req1_readdatavalid ? req1_readdata : req0_readdata), int'(e.data));
        end
      end else if (timeout_err) begin
        chk("terr_without_rdv", 1, 0);
      end
      if (!req0_waitrequest || !req1_waitrequest) begin
        chk("waitreq_owner", int'((req0_waitrequest != req1_waitrequest) && (req0_waitrequest == grant)), 1);
      end
      if (s_read && s_wait && !timeout_err) begin
        chk("cmd_stable", int'({flash_mem_read, flash_mem_address}), int'({1'b1, s_addr}));
      end
    end
    mem_rdv = 1'b0;
    if (lat_left > 0) begin
      lat_left--;
      if (lat_left == 0) begin
        mem_rdv  = 1'b1;
        mem_data = fdata(p_addr);
      end
    end
    if (flash_mem_read) begin
      if (wcount < ws_cfg) begin
        mem_wait = 1'b1;
        wcount++;
      end else begin
        mem_wait = 1'b0;
        nacc++;
        if (!no_resp) begin
          lat_left = lat_cfg;
          p_addr   = flash_mem_address;
        end
      end
    end else begin
      mem_wait = 1'b1;
      wcount   = 0;
    end
    s_read = flash_mem_read;
    s_wait = mem_wait;
    s_addr = flash_mem_address;
  end

  task automatic wait_rdv(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(req0_readdatavalid || req1_readdatavalid) && cyc < 100);
    if (!(req0_readdatavalid || req1_readdatavalid)) begin
      chk("rdv_wait_expired", 0, 1);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          cyc;
    int          n0;
    logic [22:0] ea;
    exp_t        e;
    req0_read    = v.r0;
    req1_read    = v.r1;
    req0_address = v.a0;
    req1_address = v.a1;
    ws_cfg       = v.ws;
    ea           = v.eg ? v.a1 : v.a0;
    e.port       = v.eg;
    e.data       = fdata(ea);
    e.terr       = 1'b0;
    sb.push_back(e);
    n0 = nacc;
    wait_rdv(cyc);
    chk("latency", cyc, 4 + v.ws);
    chk("grant", int'(grant), int'(v.eg));
    chk("mem_addr", int'(flash_mem_address), int'(ea));
    chk("accepts", nacc - n0, 1);
  endtask

  initial begin
    int   cyc;
    int   seen;
    exp_t e;

    vecs[0] = '{1'b1, 1'b1, 23'd1, 23'd2, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 23'd1, 23'd2, 0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 23'd1, 23'd2, 0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 23'd1, 23'd2, 0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 23'h000005, 23'd2, 0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 23'd7, 23'd2, 0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 23'd0, 23'h7FFFFF, 0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 23'd0, 23'd3, 3, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 23'd9, 23'd10, 1, 1'b0};

    mem_wait     = 1'b1;
    mem_rdv      = 1'b0;
    mem_data     = 32'h0;
    rst          = 1'b1;
    req0_read    = 1'b1;
    req1_read    = 1'b1;
    req0_address = 23'd1;
    req1_address = 23'd2;

    repeat (2) @(negedge clk);
    chk("rst_read", int'(flash_mem_read), 0);
    chk("rst_addr", int'(flash_mem_address), 0);
    chk("rst_w0", int'(req0_waitrequest), 1);
    chk("rst_w1", int'(req1_waitrequest), 1);
    chk("rst_rd0", int'(req0_readdata), 0);
    chk("rst_rd1", int'(req1_readdata), 0);
    chk("rst_rdv0", int'(req0_readdatavalid), 0);
    chk("rst_rdv1", int'(req1_readdatavalid), 0);
    chk("rst_terr", int'(timeout_err), 0);
    chk("rst_grant", int'(grant), 0);
    chk("const_write", int'(flash_mem_write), 0);
    chk("const_burst", int'(flash_mem_burstcount), 1);
    chk("const_be", int'(flash_mem_byteenable), 15);
    chk("const_wdata", int'(flash_mem_writedata), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
    end
    req0_read = 1'b0;
    req1_read = 1'b0;
    repeat (2) @(negedge clk);

    // Timeout in WAIT_DATA: accepted, flash never answers.
    no_resp      = 1'b1;
    ws_cfg       = 0;
    req0_read    = 1'b1;
    req0_address = 23'd11;
    e = '{1'b0, 32'h0, 1'b1};
    sb.push_back(e);
    wait_rdv(cyc);
    chk("to_data_latency", cyc, TO + 1);
    chk("to_data_terr", int'(timeout_err), 1);
    chk("to_data_rd0", int'(req0_readdata), 0);
    req0_read = 1'b0;
    repeat (2) @(negedge clk);

    // Timeout in ISSUE: flash never accepts the command.
    ws_cfg       = 20;
    req1_read    = 1'b1;
    req1_address = 23'd13;
    e = '{1'b1, 32'h0, 1'b1};
    sb.push_back(e);
    wait_rdv(cyc);
    chk("to_issue_latency", cyc, TO + 1);
    chk("to_issue_w1", int'(req1_waitrequest), 0);
    chk("to_issue_read", int'(flash_mem_read), 0);
    req1_read = 1'b0;
    ws_cfg    = 0;
    no_resp   = 1'b0;
    repeat (2) @(negedge clk);

    run_vec('{1'b1, 1'b0, 23'd14, 23'd0, 0, 1'b0});
    req0_read = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while waiting for data; the late flash response must be dropped.
    lat_cfg      = 4;
    req1_read    = 1'b1;
    req1_address = 23'd15;
    @(negedge clk);
    req1_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_read", int'(flash_mem_read), 0);
    chk("midrst_grant", int'(grant), 0);
    chk("midrst_w1", int'(req1_waitrequest), 1);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (req0_readdatavalid || req1_readdatavalid) seen++;
    end
    chk("midrst_stray_dropped", seen, 0);
    lat_cfg = 2;
    run_vec('{1'b1, 1'b1, 23'd20, 23'd21, 0, 1'b0});
    req0_read = 1'b0;
    req1_read = 1'b0;
    repeat (2) @(negedge clk);

    // Data arrives on the same edge as the watchdog: data wins.
    run_vec('{1'b1, 1'b0, 23'd22, 23'd0, 5, 1'b0});
    req0_read = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
